// File: rtl/io_boot_sequencer.sv
// io_boot_sequencer: top-level boot / IO control sequencer.
// Waits for the clock generator to lock. It then asks the host for a program,
// receives it under a host-inactivity watchdog, asks for input data and starts
// the core. When the core halts it parks in HALTED. From there it can re-run
// with or without re-downloading the program. A saturating counter tracks
// completed runs. It also selects which side drives the BRAM write port.
//
// Optional feature macro: IO_BOOT_SEQ_DONE_SIG_EN
//   defined   -> SIG_DONE is sent to the host after each core halt
//   undefined -> EXECUTE goes straight to HALTED
//
// Ports:
//   clk, rst        core clock, synchronous active-high reset
//   locked          clock generator locked
//   prog_recv_done  pulse: program fully received
//   rx_activity     pulse per received byte, restarts the watchdog
//   core_halt       level: core reached halt
//   rerun_req       pulse: restart execution (sampled only in HALTED)
//   reload_prog     with rerun_req: 1 = download the program again
//   tx_ready        output controller accepts a signal byte
//   tx_valid        signal byte valid
//   tx_signal       signal byte
//   tx_mode         1 = signal mode, 0 = core output (DMA) mode
//   ex_start        one-cycle core start pulse
//   bram_sel_input  1 = BRAM write port driven by the input controller
//   timeout_err     sticky watchdog error
//   run_count       completed runs, saturating
//   busy            high in every state except HALTED and ERROR
module io_boot_sequencer #(
   parameter int unsigned            SIG_W          = 8,
   parameter logic [SIG_W-1:0]       SIG_SEND_PROG  = SIG_W'(8'h99),
   parameter logic [SIG_W-1:0]       SIG_SEND_DATA  = SIG_W'(8'haa),
   parameter logic [SIG_W-1:0]       SIG_DONE       = SIG_W'(8'hbb),
   parameter int unsigned            TIMEOUT_W      = 24,
   parameter logic [TIMEOUT_W-1:0]   TIMEOUT_CYCLES = TIMEOUT_W'(10_000_000),
   parameter int unsigned            RUN_CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 locked,
   input  logic                 prog_recv_done,
   input  logic                 rx_activity,
   input  logic                 core_halt,
   input  logic                 rerun_req,
   input  logic                 reload_prog,
   input  logic                 tx_ready,
   output logic                 tx_valid,
   output logic [SIG_W-1:0]     tx_signal,
   output logic                 tx_mode,
   output logic                 ex_start,
   output logic                 bram_sel_input,
   output logic                 timeout_err,
   output logic [RUN_CNT_W-1:0] run_count,
   output logic                 busy
);

   // Watchdog value seen in the last idle cycle before the timeout fires
   localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_SEND_PROG,
      ST_PROG_RECV,
      ST_SEND_DATA,
      ST_EXECUTE,
      ST_HALTED,
      ST_ERROR
`ifdef IO_BOOT_SEQ_DONE_SIG_EN
      , ST_SEND_DONE
`endif
   } state_t;

   state_t                 state_q, state_d;
   logic [TIMEOUT_W-1:0]   wd_q, wd_d;
   logic [RUN_CNT_W-1:0]   run_cnt_d;
   logic [SIG_W-1:0]       tx_signal_d;
   logic                   tx_valid_d, tx_mode_d, ex_start_d, bram_sel_d;
   logic                   err_d, busy_d;
   logic                   hs_c, wd_expired_c, in_send_c;

`ifndef IO_BOOT_SEQ_DONE_SIG_EN
   logic unused_sig_done;
   assign unused_sig_done = ^SIG_DONE;
`endif

   // Next-state, watchdog, run counter and registered-output next values
   always_comb begin
      state_d      = state_q;
      wd_d         = wd_q;
      run_cnt_d    = run_count;
      err_d        = timeout_err;
      ex_start_d   = 1'b0;
      tx_signal_d  = tx_signal;
      in_send_c    = 1'b0;
      hs_c         = tx_valid && tx_ready;
      wd_expired_c = (TIMEOUT_CYCLES != '0) && (wd_q == WD_LAST);

      case (state_q)
         ST_INIT: begin
            if (locked) state_d = ST_SEND_PROG;
         end
         ST_SEND_PROG: begin
            in_send_c   = 1'b1;
            tx_signal_d = SIG_SEND_PROG;
            if (hs_c) state_d = ST_PROG_RECV;
         end
         ST_PROG_RECV: begin
            if (rx_activity)      wd_d = '0;
            else if (wd_q != '1)  wd_d = wd_q + TIMEOUT_W'(1);
            // A finished download beats a timeout in the same cycle
            if (prog_recv_done) begin
               state_d = ST_SEND_DATA;
            end else if (!rx_activity && wd_expired_c) begin
               state_d = ST_ERROR;
               err_d   = 1'b1;
            end
         end
         ST_SEND_DATA: begin
            in_send_c   = 1'b1;
            tx_signal_d = SIG_SEND_DATA;
            if (hs_c) begin
               state_d    = ST_EXECUTE;
               ex_start_d = 1'b1;
            end
         end
         ST_EXECUTE: begin
            if (core_halt) begin
               if (run_count != '1) run_cnt_d = run_count + RUN_CNT_W'(1);
`ifdef IO_BOOT_SEQ_DONE_SIG_EN
               state_d = ST_SEND_DONE;
`else
               state_d = ST_HALTED;
`endif
            end
         end
`ifdef IO_BOOT_SEQ_DONE_SIG_EN
         ST_SEND_DONE: begin
            in_send_c   = 1'b1;
            tx_signal_d = SIG_DONE;
            if (hs_c) state_d = ST_HALTED;
         end
`endif
         ST_HALTED: begin
            if (rerun_req) state_d = reload_prog ? ST_SEND_PROG : ST_SEND_DATA;
         end
         ST_ERROR: begin
         end
         default: state_d = ST_ERROR;
      endcase

      // Fresh watchdog window on every entry into program reception
      if (state_d == ST_PROG_RECV && state_q != ST_PROG_RECV) wd_d = '0;

      // Valid rises one cycle after entering a send state and drops on the handshake
      tx_valid_d = in_send_c && !hs_c;
      tx_mode_d  = !(state_d == ST_EXECUTE || state_d == ST_HALTED);
      bram_sel_d = (state_d == ST_PROG_RECV);
      busy_d     = !(state_d == ST_HALTED || state_d == ST_ERROR);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_INIT;
         wd_q           <= '0;
         run_count      <= '0;
         tx_valid       <= 1'b0;
         tx_signal      <= '0;
         tx_mode        <= 1'b1;
         ex_start       <= 1'b0;
         bram_sel_input <= 1'b0;
         timeout_err    <= 1'b0;
         busy           <= 1'b1;
      end else begin
         state_q        <= state_d;
         wd_q           <= wd_d;
         run_count      <= run_cnt_d;
         tx_valid       <= tx_valid_d;
         tx_signal      <= tx_signal_d;
         tx_mode        <= tx_mode_d;
         ex_start       <= ex_start_d;
         bram_sel_input <= bram_sel_d;
         timeout_err    <= err_d;
         busy           <= busy_d;
      end
   end

endmodule

// File: tb/tb_io_boot_sequencer.sv
// Testbench for io_boot_sequencer: cycle table for boot / run / re-run,
// hand-written sequences for backpressure, saturation, reset and watchdog.
// Signal bytes are checked through a scoreboard queue on every handshake.
module tb_io_boot_sequencer;

   localparam int unsigned SIG_W     = 8;
   localparam int unsigned TIMEOUT_W = 24;
   localparam int unsigned RUN_CNT_W = 2;
`ifdef IO_BOOT_SEQ_DONE_SIG_EN
   localparam bit DONE_EN = 1'b1;
`else
   localparam bit DONE_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, locked, prog_recv_done, rx_activity, core_halt;
   logic rerun_req, reload_prog, tx_ready;
   logic                 tx_valid, tx_mode, ex_start, bram_sel_input;
   logic                 timeout_err, busy;
   logic [SIG_W-1:0]     tx_signal;
   logic [RUN_CNT_W-1:0] run_count;

   always #5 clk = ~clk;

   io_boot_sequencer #(
      .TIMEOUT_CYCLES (24'd100),
      .RUN_CNT_W      (RUN_CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .locked         (locked),
      .prog_recv_done (prog_recv_done),
      .rx_activity    (rx_activity),
      .core_halt      (core_halt),
      .rerun_req      (rerun_req),
      .reload_prog    (reload_prog),
      .tx_ready       (tx_ready),
      .tx_valid       (tx_valid),
      .tx_signal      (tx_signal),
      .tx_mode        (tx_mode),
      .ex_start       (ex_start),
      .bram_sel_input (bram_sel_input),
      .timeout_err    (timeout_err),
      .run_count      (run_count),
      .busy           (busy)
   );

   // in:  {locked, prog_recv_done, rx_activity, core_halt, rerun_req, reload_prog, tx_ready}
   // ex:  {tx_valid, tx_mode, ex_start, bram_sel_input, busy, timeout_err}
   typedef struct {
      logic [6:0] in;
      logic [5:0] ex;
      logic [1:0] rc;
      logic       push;
      logic [7:0] byt;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb[$];
   int         n_vec = 0;
   int         n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_in(input logic [6:0] b);
      {locked, prog_recv_done, rx_activity, core_halt, rerun_req, reload_prog, tx_ready} = b;
   endtask

   // One clock: sample the handshake before the edge, settle after it
   task automatic step();
      logic       hs;
      logic [7:0] sig;
      logic [7:0] exp_b;
      @(negedge clk);
      hs  = tx_valid && tx_ready && !rst;
      sig = tx_signal;
      @(posedge clk);
      #1;
      if (hs) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected: byte %02h sent, none expected", sig);
         end else begin
            exp_b = sb.pop_front();
            chk("sb_byte", 32'(sig), 32'(exp_b));
         end
      end
   endtask

   task automatic add(input logic [6:0] in, input logic [5:0] ex, input logic [1:0] rc,
                      input logic push, input logic [7:0] byt);
      vec_t v;
      v.in = in; v.ex = ex; v.rc = rc; v.push = push; v.byt = byt;
      vecs.push_back(v);
   endtask

   // From the first cycle of SEND_DATA through the core halt into HALTED
   task automatic run_sd();
      set_in(7'b0000001); step();
      chk("sd_valid", 32'(tx_valid), 32'd1);
      chk("sd_sig", 32'(tx_signal), 32'h aa);
      step();
      chk("ex_pulse", 32'(ex_start), 32'd1);
      chk("ex_mode", 32'(tx_mode), 32'd0);
      set_in(7'b0000000); step();
      chk("ex_single", 32'(ex_start), 32'd0);
      set_in(7'b0001000);
      if (DONE_EN) sb.push_back(8'hbb);
      step();
      if (DONE_EN) begin
         set_in(7'b0000001); step(); step();
      end
      set_in(7'b0000000); step();
      chk("halt_busy", 32'(busy), 32'd0);
      chk("halt_valid", 32'(tx_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;

      // Boot, first run, re-run with and without reload
      for (int i = 0; i < 4; i++) add(7'b0000000, 6'b010010, 2'd0, 1'b0, 8'h00);
      add(7'b1000001, 6'b010010, 2'd0, 1'b1, 8'h99);
      add(7'b0000001, 6'b110010, 2'd0, 1'b0, 8'h00);
      add(7'b0000001, 6'b010110, 2'd0, 1'b0, 8'h00);
      add(7'b0010000, 6'b010110, 2'd0, 1'b0, 8'h00);
      add(7'b0000100, 6'b010110, 2'd0, 1'b0, 8'h00);
      add(7'b0000110, 6'b010110, 2'd0, 1'b0, 8'h00);
      add(7'b0000000, 6'b010110, 2'd0, 1'b0, 8'h00);
      add(7'b0100000, 6'b010010, 2'd0, 1'b1, 8'haa);
      add(7'b0000001, 6'b110010, 2'd0, 1'b0, 8'h00);
      add(7'b0000001, 6'b001010, 2'd0, 1'b0, 8'h00);
      add(7'b0000100, 6'b000010, 2'd0, 1'b0, 8'h00);
      add(7'b0001000, DONE_EN ? 6'b010010 : 6'b000000, 2'd1, DONE_EN, 8'hbb);
      add(7'b0000001, DONE_EN ? 6'b110010 : 6'b000000, 2'd1, 1'b0, 8'h00);
      add(7'b0000001, 6'b000000, 2'd1, 1'b0, 8'h00);
      add(7'b0000000, 6'b000000, 2'd1, 1'b0, 8'h00);
      add(7'b0000100, 6'b010010, 2'd1, 1'b1, 8'haa);
      add(7'b0000001, 6'b110010, 2'd1, 1'b0, 8'h00);
      add(7'b0000001, 6'b001010, 2'd1, 1'b0, 8'h00);
      add(7'b0001000, DONE_EN ? 6'b010010 : 6'b000000, 2'd2, DONE_EN, 8'hbb);
      add(7'b0000001, DONE_EN ? 6'b110010 : 6'b000000, 2'd2, 1'b0, 8'h00);
      add(7'b0000001, 6'b000000, 2'd2, 1'b0, 8'h00);
      add(7'b0000110, 6'b010010, 2'd2, 1'b1, 8'h99);
      add(7'b0000001, 6'b110010, 2'd2, 1'b0, 8'h00);
      add(7'b0000001, 6'b010110, 2'd2, 1'b0, 8'h00);

      // Reset values
      rst = 1'b1;
      set_in(7'b0000000);
      step(); step();
      chk("rst_valid", 32'(tx_valid), 32'd0);
      chk("rst_sig", 32'(tx_signal), 32'd0);
      chk("rst_mode", 32'(tx_mode), 32'd1);
      chk("rst_ex", 32'(ex_start), 32'd0);
      chk("rst_bram", 32'(bram_sel_input), 32'd0);
      chk("rst_err", 32'(timeout_err), 32'd0);
      chk("rst_rc", 32'(run_count), 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         set_in(vecs[i].in);
         if (vecs[i].push) sb.push_back(vecs[i].byt);
         step();
         chk($sformatf("row%0d", i),
             32'({tx_valid, tx_mode, ex_start, bram_sel_input, busy, timeout_err, run_count}),
             32'({vecs[i].ex, vecs[i].rc}));
      end

      // Third run from PROG_RECV
      set_in(7'b0100000); sb.push_back(8'haa); step();
      run_sd();
      chk("rc_run3", 32'(run_count), 32'd3);

      // Backpressure on the program request byte
      set_in(7'b0000110); sb.push_back(8'h99); step();
      set_in(7'b0000000); step();
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("bp_valid%0d", i), 32'(tx_valid), 32'd1);
         chk($sformatf("bp_sig%0d", i), 32'(tx_signal), 32'h99);
         step();
      end
      chk("bp_valid_end", 32'(tx_valid), 32'd1);
      set_in(7'b0000001); step();
      chk("bp_drop", 32'(tx_valid), 32'd0);
      chk("bp_bram", 32'(bram_sel_input), 32'd1);

      // Runs four and five: counter saturates at 3
      set_in(7'b0100000); sb.push_back(8'haa); step();
      run_sd();
      set_in(7'b0000100); sb.push_back(8'haa); step();
      run_sd();
      chk("rc_sat", 32'(run_count), 32'd3);

      // Reset while SEND_DATA is stalled: pending byte is dropped
      set_in(7'b0000100); step();
      set_in(7'b0000000); step();
      chk("pre_rst_valid", 32'(tx_valid), 32'd1);
      rst = 1'b1; step();
      chk("mid_rst_valid", 32'(tx_valid), 32'd0);
      chk("mid_rst_rc", 32'(run_count), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd1);
      chk("mid_rst_mode", 32'(tx_mode), 32'd1);
      step();
      rst = 1'b0;
      step();
      chk("init_wait", 32'(tx_valid), 32'd0);

      // Reboot into PROG_RECV
      set_in(7'b1000001); sb.push_back(8'h99); step(); step();
      chk("reboot_sig", 32'(tx_signal), 32'h99);
      step();
      chk("reboot_bram", 32'(bram_sel_input), 32'd1);

      // Watchdog kept alive by periodic activity
      set_in(7'b0000000);
      for (int i = 0; i < 10; i++) begin
         repeat (49) step();
         set_in(7'b0010000); step();
         set_in(7'b0000000);
      end
      chk("wd_alive_busy", 32'(busy), 32'd1);
      chk("wd_alive_err", 32'(timeout_err), 32'd0);

      // Silence: ERROR exactly 100 cycles after the last activity
      cnt = 0;
      while (busy === 1'b1 && cnt < 200) begin
         step();
         cnt++;
      end
      chk("wd_cycles", 32'(cnt), 32'd100);
      chk("wd_err", 32'(timeout_err), 32'd1);
      chk("wd_bram", 32'(bram_sel_input), 32'd0);

      // ERROR is terminal: late download completion and rerun ignored
      set_in(7'b0100000); step();
      set_in(7'b0000110); step();
      set_in(7'b0000001); repeat (3) step();
      chk("err_busy", 32'(busy), 32'd0);
      chk("err_sticky", 32'(timeout_err), 32'd1);
      chk("err_valid", 32'(tx_valid), 32'd0);
      chk("err_ex", 32'(ex_start), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
